// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine driving a combinational-read data RAM; supports byte/half/word
// loads and stores plus an atomic SWAP. Define ALIGN_CHECK_EN to fault misaligned accesses.
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_sel,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [3:0] OP_LB   = 4'd0;
    localparam logic [3:0] OP_LBU  = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LW   = 4'd4;
    localparam logic [3:0] OP_SB   = 4'd5;
    localparam logic [3:0] OP_SH   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_SWAP = 4'd8;

    typedef enum logic [1:0] {IDLE, ACCESS, SWAP_WR, RESP} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          op_reg, op_next;
    logic [1:0]          off_reg, off_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic                ram_ce_reg, ram_ce_next;
    logic                ram_we_reg, ram_we_next;
    logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
    logic [3:0]          ram_sel_reg, ram_sel_next;
    logic [DATA_W-1:0]   ram_wdata_reg, ram_wdata_next;
    logic                resp_valid_reg, resp_valid_next;
    logic [DATA_W-1:0]   resp_rdata_reg, resp_rdata_next;
    logic                resp_err_reg, resp_err_next;

    logic                req_illegal;
    logic                req_misaligned;
    logic                req_is_store;
    logic [3:0]          req_sel;
    logic [DATA_W-1:0]   req_wdata_rep;
    logic [DATA_W-1:0]   load_data;
    logic [7:0]          rd_byte [4];
    logic [7:0]          byte_val;
    logic [15:0]         half_val;

    assign req_ready    = (state_reg == IDLE) && !rst;
    assign req_illegal  = (req_op > OP_SWAP);
    assign req_is_store = (req_op == OP_SB) || (req_op == OP_SH) || (req_op == OP_SW);

`ifdef ALIGN_CHECK_EN
    assign req_misaligned =
        (((req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH)) && req_addr[0]) ||
        (((req_op == OP_LW) || (req_op == OP_SW) || (req_op == OP_SWAP)) && (req_addr[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    // Big-endian lanes: byte offset 0 lives in ram_sel[3] / bits [31:24].
    always_comb begin
        req_sel       = 4'b1111;
        req_wdata_rep = req_wdata;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: begin
                req_sel       = 4'b1000 >> req_addr[1:0];
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                req_sel       = req_addr[1] ? 4'b0011 : 4'b1100;
                req_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = ram_rdata[gi*8 +: 8];
        end
    endgenerate

    assign byte_val = rd_byte[2'd3 - off_reg];
    assign half_val = off_reg[1] ? ram_rdata[15:0] : ram_rdata[31:16];

    always_comb begin
        load_data = '0;
        case (op_reg)
            OP_LB:   load_data = {{24{byte_val[7]}}, byte_val};
            OP_LBU:  load_data = {24'h0, byte_val};
            OP_LH:   load_data = {{16{half_val[15]}}, half_val};
            OP_LHU:  load_data = {16'h0, half_val};
            OP_LW:   load_data = ram_rdata;
            OP_SWAP: load_data = ram_rdata;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        off_next        = off_reg;
        wdata_next      = wdata_reg;
        ram_ce_next     = ram_ce_reg;
        ram_we_next     = ram_we_reg;
        ram_addr_next   = ram_addr_reg;
        ram_sel_next    = ram_sel_reg;
        ram_wdata_next  = ram_wdata_reg;
        resp_valid_next = resp_valid_reg;
        resp_rdata_next = resp_rdata_reg;
        resp_err_next   = resp_err_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready) begin
                    op_next         = req_op;
                    off_next        = req_addr[1:0];
                    wdata_next      = req_wdata;
                    resp_rdata_next = '0;
                    resp_err_next   = 1'b0;
                    if (req_illegal || req_misaligned) begin
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        resp_err_next   = 1'b1;
                    end else begin
                        state_next     = ACCESS;
                        ram_ce_next    = 1'b1;
                        ram_we_next    = req_is_store;
                        ram_addr_next  = {req_addr[ADDR_W-1:2], 2'b00};
                        ram_sel_next   = req_sel;
                        ram_wdata_next = req_wdata_rep;
                    end
                end
            end
            ACCESS: begin
                resp_rdata_next = load_data;
                if (op_reg == OP_SWAP) begin
                    state_next     = SWAP_WR;
                    ram_we_next    = 1'b1;
                    ram_sel_next   = 4'b1111;
                    ram_wdata_next = wdata_reg;
                end else begin
                    state_next      = RESP;
                    ram_ce_next     = 1'b0;
                    ram_we_next     = 1'b0;
                    resp_valid_next = 1'b1;
                end
            end
            SWAP_WR: begin
                state_next      = RESP;
                ram_ce_next     = 1'b0;
                ram_we_next     = 1'b0;
                resp_valid_next = 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    state_next      = IDLE;
                    resp_valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            op_reg         <= '0;
            off_reg        <= '0;
            wdata_reg      <= '0;
            ram_ce_reg     <= 1'b0;
            ram_we_reg     <= 1'b0;
            ram_addr_reg   <= '0;
            ram_sel_reg    <= '0;
            ram_wdata_reg  <= '0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            off_reg        <= off_next;
            wdata_reg      <= wdata_next;
            ram_ce_reg     <= ram_ce_next;
            ram_we_reg     <= ram_we_next;
            ram_addr_reg   <= ram_addr_next;
            ram_sel_reg    <= ram_sel_next;
            ram_wdata_reg  <= ram_wdata_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
            resp_err_reg   <= resp_err_next;
        end
    end

    assign ram_ce     = ram_ce_reg;
    assign ram_we     = ram_we_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_sel    = ram_sel_reg;
    assign ram_wdata  = ram_wdata_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small byte-enabled RAM model.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:63];

    int n_checks = 0;
    int n_pass   = 0;

    // Values captured by xact during the first cycle after acceptance.
    logic        cap_ce, cap_we, ce_seen;
    logic [3:0]  cap_sel;
    logic [31:0] cap_wdata;
    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_sel    (ram_sel),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ram_rdata = (ram_ce && !ram_we) ? mem[ram_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            if (ram_sel[3]) mem[ram_addr[7:2]][31:24] <= ram_wdata[31:24];
            if (ram_sel[2]) mem[ram_addr[7:2]][23:16] <= ram_wdata[23:16];
            if (ram_sel[1]) mem[ram_addr[7:2]][15:8]  <= ram_wdata[15:8];
            if (ram_sel[0]) mem[ram_addr[7:2]][7:0]   <= ram_wdata[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One request/response; hold>0 keeps resp_ready low that many cycles and pulses req_valid.
    task automatic xact(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold);
        int cyc;
        logic [31:0] first_rdata;
        @(negedge clk);
        req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        cyc = 0;
        ce_seen = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                cap_ce = ram_ce; cap_we = ram_we; cap_sel = ram_sel; cap_wdata = ram_wdata;
            end
            ce_seen = ce_seen | ram_ce;
        end while (!resp_valid && cyc < 10);
        if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
        got_lat   = cyc;
        got_rdata = resp_rdata;
        got_err   = resp_err;
        first_rdata = resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            req_valid = (i == 0);
            if (i == 0) begin
                req_op = 4'd7; req_addr = 32'h30; req_wdata = 32'hBAD0BAD0;
            end
            check("hold_valid", resp_valid, 1'b1);
            check("hold_rdata", resp_rdata, first_rdata);
            check("hold_req_ready", req_ready, 1'b0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        $display("xact op=%h addr=%h wdata=%h rdata=%h err=%b lat=%0d", op, addr, wd,
                 got_rdata, got_err, got_lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[8]  = 32'h11223344;
        mem[10] = 32'h55667788;
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 4'd0; req_addr = 32'h0; req_wdata = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_ram_ce", ram_ce, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_sel", ram_sel, 4'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_req_ready", req_ready, 1'b0);
        rst = 1'b0;
        #1 check("idle_req_ready", req_ready, 1'b1);

        xact(4'd7, 32'h10, 32'hA1B2C3D4, 0);   // SW
        check("sw_ce", cap_ce, 1'b1);
        check("sw_we", cap_we, 1'b1);
        check("sw_sel", cap_sel, 4'b1111);
        check("sw_wdata", cap_wdata, 32'hA1B2C3D4);
        check("sw_rdata", got_rdata, 32'h0);
        check("sw_lat", got_lat, 32'd2);
        @(negedge clk);
        check("resp_valid_drop", resp_valid, 1'b0);

        xact(4'd0, 32'h11, 32'h0, 0);          // LB
        check("lb_we", cap_we, 1'b0);
        check("lb_sel", cap_sel, 4'b0100);
        check("lb_rdata", got_rdata, 32'hFFFFFFB2);
        check("lb_err", got_err, 1'b0);
        check("lb_lat", got_lat, 32'd2);

        xact(4'd5, 32'h13, 32'h0000005E, 0);   // SB
        check("sb_sel", cap_sel, 4'b0001);
        check("sb_wdata", cap_wdata, 32'h5E5E5E5E);

        xact(4'd3, 32'h12, 32'h0, 0);          // LHU
        check("lhu_sel", cap_sel, 4'b0011);
        check("lhu_rdata", got_rdata, 32'h0000C35E);

        xact(4'd2, 32'h10, 32'h0, 0);          // LH
        check("lh_rdata", got_rdata, 32'hFFFFA1B2);

        xact(4'd1, 32'h13, 32'h0, 0);          // LBU
        check("lbu_rdata", got_rdata, 32'h0000005E);

        xact(4'd0, 32'h12, 32'h0, 0);          // LB negative
        check("lb2_rdata", got_rdata, 32'hFFFFFFC3);

        xact(4'd8, 32'h20, 32'hDEADBEEF, 0);   // SWAP
        check("swap_first_we", cap_we, 1'b0);
        check("swap_rdata", got_rdata, 32'h11223344);
        check("swap_lat", got_lat, 32'd3);
        check("swap_mem", mem[8], 32'hDEADBEEF);

        xact(4'd4, 32'h20, 32'h0, 4);          // LW with stalled consumer
        check("lw_rdata", got_rdata, 32'hDEADBEEF);

        xact(4'd4, 32'h30, 32'h0, 0);          // pulse during stall must not have stored
        check("ignored_pulse", got_rdata, 32'h0);

        xact(4'd6, 32'h16, 32'h1234ABCD, 0);   // SH
        check("sh_sel", cap_sel, 4'b0011);
        check("sh_wdata", cap_wdata, 32'hABCDABCD);
        xact(4'd4, 32'h14, 32'h0, 0);
        check("sh_readback", got_rdata, 32'h0000ABCD);

        xact(4'b1010, 32'h10, 32'h0, 0);       // illegal op
        check("ill_ce", ce_seen, 1'b0);
        check("ill_err", got_err, 1'b1);
        check("ill_rdata", got_rdata, 32'h0);
        check("ill_lat", got_lat, 32'd1);

        xact(4'd4, 32'h22, 32'h0, 0);          // word access at offset 2
`ifdef ALIGN_CHECK_EN
        check("mis_ce", ce_seen, 1'b0);
        check("mis_err", got_err, 1'b1);
        check("mis_rdata", got_rdata, 32'h0);
`else
        check("unal_err", got_err, 1'b0);
        check("unal_rdata", got_rdata, 32'hDEADBEEF);
`endif

        // Reset asserted while SWAP is in its write phase.
        @(negedge clk);
        req_op = 4'd8; req_addr = 32'h28; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("swapwr_ce", ram_ce, 1'b1);
        check("swapwr_we", ram_we, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_ce", ram_ce, 1'b0);
        check("abort_we", ram_we, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_req_ready", req_ready, 1'b1);
        check("abort_resp_valid", resp_valid, 1'b0);
        check("abort_mem", mem[10], 32'h55667788);
        $display("xact op=8 addr=00000028 wdata=cafef00d aborted by reset");

        xact(4'd4, 32'h28, 32'h0, 0);
        check("post_reset_lw", got_rdata, 32'h55667788);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
